// File: rtl/skid_fifo_flush.sv
// Multi-entry elastic buffer between two valid/ready stages with a synchronous flush.
// It keeps full throughput at every occupancy, including enqueue while full if the consumer dequeues in the same cycle.
module skid_fifo_flush #(
    parameter type T     = logic,
    parameter int  DEPTH = 4,
    parameter int  CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          flush,
    input  logic          valid_in,
    output logic          ready_in,
    input  T              data_in,
    output logic          valid_out,
    input  logic          ready_out,
    output T              data_out,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          almost_full,
    output logic          empty
);

    localparam int            AW        = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [CW-1:0] AFULL_CNT = CW'(DEPTH - 1);

    T              mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          enq;
    logic          deq;

    assign full        = (count == FULL_CNT);
    assign almost_full = (count >= AFULL_CNT);
    assign empty       = (count == '0);

    // A full buffer still accepts when the head leaves in the same cycle.
    assign ready_in  = !flush && (!full || ready_out);
    assign valid_out = !flush && !empty;
    assign data_out  = mem[rd_ptr];

    assign enq = valid_in && ready_in;
    assign deq = valid_out && ready_out;

    // NOTE: storage has no reset, because the pointers and count alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (enq) begin
            mem[wr_ptr] <= data_in;
        end
    end

    // NOTE: state registers use non-blocking assignments, so every branch samples values from before the edge.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= AW'(wr_ptr + 1'b1);
            end
            if (deq) begin
                rd_ptr <= AW'(rd_ptr + 1'b1);
            end
            if (enq && !deq) begin
                count <= CW'(count + 1'b1);
            end else if (deq && !enq) begin
                count <= CW'(count - 1'b1);
            end
        end
    end

endmodule

// File: tb/tb_skid_fifo_flush.sv
// Self-checking bench for skid_fifo_flush (DEPTH=4, 8-bit payload).
// It checks table vectors, directed corner cases, and random traffic against a queue-based reference model.
module tb_skid_fifo_flush;

    logic       clk = 1'b0;
    logic       reset, flush, valid_in, ready_out;
    logic [7:0] data_in;
    logic       ready_in, valid_out, full, almost_full, empty;
    logic [7:0] data_out;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] model_q [$];

    typedef struct {
        logic       vi;
        logic [7:0] d;
        logic       ro;
        logic       exp_ri;
        logic       exp_vo;
        logic [7:0] exp_dout;
        int         exp_cnt;
    } vec_t;

    vec_t tbl [10];

    skid_fifo_flush #(.T(logic [7:0]), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .valid_in   (valid_in),
        .ready_in   (ready_in),
        .data_in    (data_in),
        .valid_out  (valid_out),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .count      (count),
        .full       (full),
        .almost_full(almost_full),
        .empty      (empty)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic r, input logic f, input logic vi, input logic [7:0] d, input logic ro);
        reset     = r;
        flush     = f;
        valid_in  = vi;
        data_in   = d;
        ready_out = ro;
    endtask

    // Model expectations depend only on the queue contents and the inputs being applied.
    function automatic logic model_ready_in();
        return !flush && (model_q.size() < 4 || ready_out);
    endfunction

    function automatic logic model_valid_out();
        return !flush && (model_q.size() > 0);
    endfunction

    task automatic model_check();
        check("ready_in", ready_in, model_ready_in());
        check("valid_out", valid_out, model_valid_out());
        if (model_valid_out()) check("data_out", data_out, model_q[0]);
        check("count", count, model_q.size());
        check("full", full, model_q.size() == 4);
        check("almost_full", almost_full, model_q.size() >= 3);
        check("empty", empty, model_q.size() == 0);
    endtask

    task automatic model_step();
        logic e, q;
        e = valid_in && model_ready_in();
        q = model_valid_out() && ready_out;
        if (reset || flush) begin
            model_q.delete();
        end else begin
            if (q) void'(model_q.pop_front());
            if (e) model_q.push_back(data_in);
        end
    endtask

    // One cycle: inputs settle, the model checks outputs, then the clock edge advances both sides.
    task automatic cycle(input logic r, input logic f, input logic vi, input logic [7:0] d, input logic ro);
        drive(r, f, vi, d, ro);
        #1;
        model_check();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        tbl[0] = '{1'b1, 8'h11, 1'b0, 1'b1, 1'b0, 8'h00, 0};
        tbl[1] = '{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 8'h11, 1};
        tbl[2] = '{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 8'h11, 2};
        tbl[3] = '{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 8'h11, 3};
        tbl[4] = '{1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 8'h11, 4};
        tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 4};
        tbl[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h22, 3};
        tbl[7] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h33, 2};
        tbl[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h44, 1};
        tbl[9] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00, 0};

        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(posedge clk);
        #1;
        do_reset();

        // Reset state
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_afull", almost_full, 0);
        check("rst_valid_out", valid_out, 0);
        check("rst_ready_in", ready_in, 1);

        // Fill/drain table
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, tbl[i].vi, tbl[i].d, tbl[i].ro);
            #1;
            check($sformatf("tbl%0d_ready_in", i), ready_in, tbl[i].exp_ri);
            check($sformatf("tbl%0d_valid_out", i), valid_out, tbl[i].exp_vo);
            if (tbl[i].exp_vo) check($sformatf("tbl%0d_data_out", i), data_out, tbl[i].exp_dout);
            check($sformatf("tbl%0d_count", i), count, tbl[i].exp_cnt);
            check($sformatf("tbl%0d_full", i), full, tbl[i].exp_cnt == 4);
            check($sformatf("tbl%0d_afull", i), almost_full, tbl[i].exp_cnt >= 3);
            check($sformatf("tbl%0d_empty", i), empty, tbl[i].exp_cnt == 0);
            model_step();
            @(posedge clk);
            #1;
        end

        // Full with simultaneous dequeue
        do_reset();
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b1, 8'hA0 + 8'(i), 1'b0);
        drive(1'b0, 1'b0, 1'b1, 8'hA4, 1'b1);
        #1;
        check("fulldeq_ready_in", ready_in, 1);
        check("fulldeq_head", data_out, 8'hA0);
        model_step();
        @(posedge clk);
        #1;
        check("fulldeq_count", count, 4);
        for (int i = 1; i <= 4; i++) begin
            drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            #1;
            check("fulldeq_order", data_out, 8'hA0 + 8'(i));
            model_step();
            @(posedge clk);
            #1;
        end
        check("fulldeq_empty", empty, 1);

        // Streaming
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 8'(i), 1'b1);
            #1;
            if (i > 0) begin
                check("stream_data", data_out, 8'(i - 1));
                check("stream_count", count, 1);
            end
            model_check();
            model_step();
            @(posedge clk);
            #1;
        end
        cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Flush while holding three entries
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
        drive(1'b0, 1'b1, 1'b1, 8'h77, 1'b1);
        #1;
        check("flush_valid_out", valid_out, 0);
        check("flush_ready_in", ready_in, 0);
        model_step();
        @(posedge clk);
        #1;
        check("flush_count", count, 0);
        check("flush_empty", empty, 1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);

        // Reset during active handshakes, then reset combined with flush
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 8'h30 + 8'(i), 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h99, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rstmid_count", count, 0);
        check("rstmid_valid_out", valid_out, 0);
        check("rstmid_ready_in", ready_in, 1);
        for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b1, 8'h40 + 8'(i), 1'b0);
        cycle(1'b1, 1'b1, 1'b1, 8'h98, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("rstflush_count", count, 0);
        check("rstflush_empty", empty, 1);

        // Random traffic with an occasional flush
        for (int i = 0; i < 1000; i++) begin
            cycle(1'b0, ($urandom % 64) == 0, 1'($urandom % 2), 8'($urandom), 1'($urandom % 2));
        end
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        check("final_empty", empty, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/skid_fifo_flush.md
# skid_fifo_flush

Parametrised multi-entry elastic buffer: the generalised successor of the single-entry pipeline skid stage. It holds up to DEPTH items of an arbitrary struct type between two valid/ready stages and sustains full throughput, including enqueue-while-full when the consumer drains in the same cycle. It adds a synchronous flush for branch-mispredict and exception recovery, plus occupancy status. Intended between front-end, rename and dispatch stages of the out-of-order core.

## Interface
- T, default logic: payload type (packed struct or vector).
- DEPTH, default 4: number of entries; power of two, ≥ 2.
- CW, default $clog2(DEPTH+1): derived width of count; not to be overridden.

- clk  input  1  clock, all state on rising edge.
- reset  input  1  reset, synchronous, active-high.
- flush  input  1  synchronous discard of all entries and any same-cycle enqueue.
- valid_in  input  1  producer has data_in.
- ready_in  output  1  buffer accepts data_in this cycle.
- data_in  input  T  payload from producer.
- valid_out  output  1  head entry presented to consumer.
- ready_out  input  1  consumer takes head this cycle.
- data_out  output  T  head payload; don't-care when valid_out=0.
- count  output  CW  entries held, 0..DEPTH.
- full  output  1  count == DEPTH.
- almost_full  output  1  count ≥ DEPTH-1.
- empty  output  1  count == 0.

## Operation
- Storage: circular array mem[DEPTH] of T; wr_ptr, rd_ptr of $clog2(DEPTH) bits, wrap naturally modulo DEPTH; count held as a separate register. Array contents are not reset.
- enq = valid_in && ready_in; deq = valid_out && ready_out.
- ready_in = !flush && (!full || ready_out). Enqueue into a full buffer is legal only with a simultaneous dequeue (combinational ready_out→ready_in path, same as the single-entry stage).
- valid_out = !flush && !empty. data_out = mem[rd_ptr].
- enq: mem[wr_ptr] <= data_in, wr_ptr++. deq: rd_ptr++.
- count next: +1 on enq only, −1 on deq only, unchanged on both or neither.
- Simultaneous enq+deq when count==1: the head leaves and the new item becomes the head next cycle; no data corruption.
- flush (no reset): wr_ptr, rd_ptr, count <= 0. Because ready_in and valid_out are masked, no handshake completes in the flush cycle, so the item on data_in that cycle is dropped and the head is not consumed.
- Priority: reset > flush > enq/deq.
- FIFO order strictly preserved; no item duplicated or lost except by flush.

## Timing
- Reset values (cycle after reset high): count=0, empty=1, full=0, almost_full=0, valid_out=0, ready_in=1 (if flush low), pointers 0.
- Latency: an item accepted at edge N is visible on valid_out/data_out after edge N (next cycle) if the buffer was empty; no combinational data_in→data_out path.
- Throughput: one enq and one deq per cycle sustained at any occupancy, including full.
- full, almost_full, empty, count are registered-state derived and change only after a clock edge; ready_in and valid_out additionally respond combinationally to flush and ready_out.
- Reset or flush asserted mid-stream: takes effect at that edge; buffer empty the next cycle regardless of in-flight handshakes.
- valid_out once high stays high with data_out stable until deq, flush or reset.

## Test plan
- Fill/drain (DEPTH=4, T=8-bit): ready_out=0, push 0x11,0x22,0x33,0x44 → count 1,2,3,4, almost_full at 3, full at 4, ready_in=0; push 0x55 ignored; set ready_out=1 → outputs 0x11..0x44 in order, then empty=1.
- Full-with-simultaneous-dequeue: full with 0xA0..0xA3, valid_in=1 data 0xA4 and ready_out=1 same cycle → ready_in=1, count stays 4, next head 0xA1, 0xA4 emerges fourth.
- Streaming: valid_in and ready_out held 1 for 20 cycles, data 0..19 → data_out 0..19 one per cycle, one cycle behind, count steady at 1.
- Flush: hold 3 entries, assert flush with valid_in=1 data 0x77, ready_out=1 → valid_out=0 and ready_in=0 that cycle; next cycle count=0, empty=1; 0x77 never appears.
- Wrap-around: random valid_in/ready_out (50%) for 1000 cycles against a scoreboard → order preserved, count matches model, pointers wrap past DEPTH-1 cleanly.
- Reset mid-operation: reset high with 2 entries and active handshakes → next cycle count=0, valid_out=0, ready_in=1; reset together with flush behaves as reset.
